// File: rtl/clock_pkg.sv
// Shared types and constants for the timekeeping controller.
// Holds the FSM state encoding, set-field codes, field limits and wrap-increment helpers.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_HOUR,
    ST_SET_MIN,
    ST_SET_SEC,
    ST_COMMIT
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HOUR = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } field_e;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

  function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] v);
    return (v >= HOUR_MAX) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [MIN_W-1:0] inc_wrap6(input logic [MIN_W-1:0] v,
                                                 input logic [MIN_W-1:0] max);
    return (v >= max) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Front-panel / counter-chain bundle around the clock controller.
// master = environment (buttons, live time); slave = the controller itself.
interface clock_ctrl_if;
  import clock_pkg::*;

  logic              btn_mode;
  logic              btn_inc;
  logic [HOUR_W-1:0] cur_hour;
  logic [MIN_W-1:0]  cur_min;
  logic [SEC_W-1:0]  cur_sec;

  logic              ms_tick;
  logic              run;
  logic              load_en;
  logic [HOUR_W-1:0] load_hour;
  logic [MIN_W-1:0]  load_min;
  logic [SEC_W-1:0]  load_sec;
  logic [1:0]        set_field;
  logic              blink;

  modport master (
    output btn_mode, btn_inc, cur_hour, cur_min, cur_sec,
    input  ms_tick, run, load_en, load_hour, load_min, load_sec, set_field, blink
  );

  modport slave (
    input  btn_mode, btn_inc, cur_hour, cur_min, cur_sec,
    output ms_tick, run, load_en, load_hour, load_min, load_sec, set_field, blink
  );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV counter; tick is high in the last count of each period.
// clr restarts the period so the next tick lands exactly DIV cycles later.
module tick_prescaler #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_div_check
    $error("tick_prescaler: DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt_q <= '0;
    else if (clr || tick)  cnt_q <= '0;
    else                   cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/clock_ctrl.sv
// Run/stop and set-mode controller for the hh:mm:ss counter chain.
// Edits happen on shadow registers and are pushed to the chain with a single load strobe.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50000000,
  parameter int TICK_HZ       = 1000,
  parameter int TIMEOUT_TICKS = 10000,
  parameter int BLINK_TICKS   = 500
) (
  input  logic         clk,
  input  logic         reset,
  clock_ctrl_if.slave  bus
);
  localparam int DIV  = CLK_FREQ_HZ / TICK_HZ;
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int BL_W = $clog2(BLINK_TICKS + 1);

  state_e            state_q, state_d;
  logic              tick, presc_clr, in_set;
  logic [HOUR_W-1:0] sh_hour_q, sh_hour_d, ld_hour_q, ld_hour_d;
  logic [MIN_W-1:0]  sh_min_q, sh_min_d, ld_min_q, ld_min_d;
  logic [SEC_W-1:0]  sh_sec_q, sh_sec_d, ld_sec_q, ld_sec_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [BL_W-1:0]   bl_cnt_q, bl_cnt_d;
  logic              blink_q, blink_d;
  field_e            field;

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk   (clk),
    .reset (reset),
    .clr   (presc_clr),
    .tick  (tick)
  );

  assign in_set = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN) || (state_q == ST_SET_SEC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      sh_hour_q <= '0;
      sh_min_q  <= '0;
      sh_sec_q  <= '0;
      ld_hour_q <= '0;
      ld_min_q  <= '0;
      ld_sec_q  <= '0;
      to_cnt_q  <= '0;
      bl_cnt_q  <= '0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_hour_q <= sh_hour_d;
      sh_min_q  <= sh_min_d;
      sh_sec_q  <= sh_sec_d;
      ld_hour_q <= ld_hour_d;
      ld_min_q  <= ld_min_d;
      ld_sec_q  <= ld_sec_d;
      to_cnt_q  <= to_cnt_d;
      bl_cnt_q  <= bl_cnt_d;
      blink_q   <= blink_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_hour_d = sh_hour_q;
    sh_min_d  = sh_min_q;
    sh_sec_d  = sh_sec_q;
    ld_hour_d = ld_hour_q;
    ld_min_d  = ld_min_q;
    ld_sec_d  = ld_sec_q;
    to_cnt_d  = to_cnt_q;
    bl_cnt_d  = bl_cnt_q;
    blink_d   = blink_q;
    presc_clr = 1'b0;

    // Blink phase runs continuously across all three set states.
    if (in_set && tick) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (bl_cnt_q == BL_W'(BLINK_TICKS - 1)) begin
        bl_cnt_d = '0;
        blink_d  = ~blink_q;
      end else begin
        bl_cnt_d = bl_cnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (bus.btn_mode) begin
          sh_hour_d = (bus.cur_hour > HOUR_MAX) ? '0 : bus.cur_hour;
          sh_min_d  = (bus.cur_min  > MIN_MAX)  ? '0 : bus.cur_min;
          sh_sec_d  = (bus.cur_sec  > SEC_MAX)  ? '0 : bus.cur_sec;
          to_cnt_d  = '0;
          bl_cnt_d  = '0;
          blink_d   = 1'b1;
          state_d   = ST_SET_HOUR;
        end
      end
      ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
        if (bus.btn_mode) begin
          to_cnt_d = '0;
          if (state_q == ST_SET_HOUR)     state_d = ST_SET_MIN;
          else if (state_q == ST_SET_MIN) state_d = ST_SET_SEC;
          else begin
            state_d   = ST_COMMIT;
            ld_hour_d = sh_hour_q;
            ld_min_d  = sh_min_q;
            ld_sec_d  = sh_sec_q;
          end
        end else if (bus.btn_inc) begin
          to_cnt_d = '0;
          if (state_q == ST_SET_HOUR)     sh_hour_d = inc_hour(sh_hour_q);
          else if (state_q == ST_SET_MIN) sh_min_d  = inc_wrap6(sh_min_q, MIN_MAX);
          else                            sh_sec_d  = inc_wrap6(sh_sec_q, SEC_MAX);
        end else if (tick && to_cnt_q == TO_W'(TIMEOUT_TICKS - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_COMMIT: begin
        presc_clr = 1'b1;
        state_d   = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    field = FIELD_NONE;
    case (state_q)
      ST_SET_HOUR: field = FIELD_HOUR;
      ST_SET_MIN:  field = FIELD_MIN;
      ST_SET_SEC:  field = FIELD_SEC;
      default:     field = FIELD_NONE;
    endcase
  end

  assign bus.ms_tick   = tick && (state_q == ST_RUN);
  assign bus.run       = (state_q == ST_RUN);
  assign bus.load_en   = (state_q == ST_COMMIT);
  assign bus.load_hour = ld_hour_q;
  assign bus.load_min  = ld_min_q;
  assign bus.load_sec  = ld_sec_q;
  assign bus.set_field = field;
  assign bus.blink     = in_set && blink_q;
endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: a cycle-level behavioural model plus directed literal checks.
module tb_clock_ctrl;
  localparam int DIV     = 10;
  localparam int TIMEOUT = 5;
  localparam int BLINK   = 2;

  logic clk;
  logic rst_n;
  clock_ctrl_if bus();

  clock_ctrl #(
    .CLK_FREQ_HZ   (10),
    .TICK_HZ       (1),
    .TIMEOUT_TICKS (TIMEOUT),
    .BLINK_TICKS   (BLINK)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=run, 1..3=editing field, 4=commit.
  int m_mode, m_cyc, m_base, m_idle, m_set_ticks;
  int m_sh[3];
  int m_ld[3];
  int m_max[3] = '{23, 59, 59};

  function automatic bit m_tick();
    return ((m_cyc - m_base) % DIV) == DIV - 1;
  endfunction

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? 0 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_cyc = 0; m_base = 0; m_idle = 0; m_set_ticks = 0;
      for (int i = 0; i < 3; i++) begin m_sh[i] = 0; m_ld[i] = 0; end
    end else begin
      bit t;
      bit was_commit;
      t = m_tick();
      was_commit = (m_mode == 4);
      if (m_mode == 0) begin
        if (bus.btn_mode) begin
          m_sh[0] = clampv(int'(bus.cur_hour), 23);
          m_sh[1] = clampv(int'(bus.cur_min), 59);
          m_sh[2] = clampv(int'(bus.cur_sec), 59);
          m_mode = 1; m_idle = 0; m_set_ticks = 0;
        end
      end else if (m_mode == 4) begin
        m_mode = 0;
      end else begin
        if (t) m_set_ticks++;
        if (bus.btn_mode) begin
          m_idle = 0;
          if (m_mode == 3) begin
            for (int i = 0; i < 3; i++) m_ld[i] = m_sh[i];
          end
          m_mode++;
        end else if (bus.btn_inc) begin
          m_idle = 0;
          m_sh[m_mode-1] = (m_sh[m_mode-1] + 1) % (m_max[m_mode-1] + 1);
        end else if (t) begin
          m_idle++;
          if (m_idle >= TIMEOUT) m_mode = 0;
        end
      end
      m_cyc++;
      if (was_commit) m_base = m_cyc;
    end
  end

  // Single compare process: every cycle, every output against the model.
  always @(negedge clk) begin
    bit in_set;
    in_set = (m_mode >= 1 && m_mode <= 3);
    chk("ms_tick",   int'(bus.ms_tick),   int'(m_tick() && m_mode == 0));
    chk("run",       int'(bus.run),       int'(m_mode == 0));
    chk("load_en",   int'(bus.load_en),   int'(m_mode == 4));
    chk("load_hour", int'(bus.load_hour), m_ld[0]);
    chk("load_min",  int'(bus.load_min),  m_ld[1]);
    chk("load_sec",  int'(bus.load_sec),  m_ld[2]);
    chk("set_field", int'(bus.set_field), in_set ? m_mode : 0);
    chk("blink",     int'(bus.blink),     in_set ? int'(((m_set_ticks / BLINK) % 2) == 0) : 0);
  end

  // Event monitor feeding the literal checks.
  int n_load = 0, cap_h = -1, cap_m = -1, cap_s = -1;
  int gap = -1, gap_cnt = 0, blink_chg = 0;
  bit gap_armed = 0;
  logic prev_blink = 1'b0;
  always @(negedge clk) begin
    if (bus.load_en) begin
      n_load++;
      cap_h = int'(bus.load_hour); cap_m = int'(bus.load_min); cap_s = int'(bus.load_sec);
      gap_armed = 1; gap_cnt = 0;
    end else if (gap_armed) begin
      gap_cnt++;
      if (bus.ms_tick) begin gap = gap_cnt; gap_armed = 0; end
    end
    if (bus.blink !== prev_blink) blink_chg++;
    prev_blink = bus.blink;
  end

  task automatic drive(input bit m, input bit i);
    @(negedge clk); #1;
    bus.btn_mode = m;
    bus.btn_inc  = i;
  endtask

  task automatic pulse(input bit m, input bit i);
    drive(m, i);
    drive(0, 0);
  endtask

  task automatic set_cur(input int h, input int mi, input int s);
    bus.cur_hour = 5'(h); bus.cur_min = 6'(mi); bus.cur_sec = 6'(s);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0);
  endtask

  initial begin
    int ticks[$];
    int first_k;
    int loads_before;

    rst_n = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    set_cur(0, 0, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: ticks land on edges 10/20/30.
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (bus.ms_tick) ticks.push_back(k);
    end
    chk("idle_tick_count", ticks.size(), 3);
    if (ticks.size() == 3) begin
      chk("idle_tick0", ticks[0] + 1, 10);
      chk("idle_tick1", ticks[1] + 1, 20);
      chk("idle_tick2", ticks[2] + 1, 30);
    end
    chk("idle_no_load", n_load, 0);
    $display("idle: %0d ticks seen", ticks.size());

    // Full edit from 23:59:58 to 00:01:01.
    set_cur(23, 59, 58);
    gap = -1;
    pulse(1, 0);
    pulse(0, 1);
    pulse(1, 0);
    pulse(0, 1); pulse(0, 1);
    chk("edit_run_low", int'(bus.run), 0);
    pulse(1, 0);
    pulse(0, 1); pulse(0, 1); pulse(0, 1);
    pulse(1, 0);
    idle(15);
    chk("edit_load_count", n_load, 1);
    chk("edit_load_hour", cap_h, 0);
    chk("edit_load_min", cap_m, 1);
    chk("edit_load_sec", cap_s, 1);
    chk("edit_tick_gap", gap, DIV);
    $display("edit: loaded %0d:%0d:%0d, tick gap %0d", cap_h, cap_m, cap_s, gap);

    // Minute wrap 59 -> 0 leaves hour alone.
    set_cur(10, 59, 30);
    pulse(1, 0); pulse(1, 0);
    chk("wrap_field_min", int'(bus.set_field), 2);
    pulse(0, 1);
    chk("wrap_field_min_after", int'(bus.set_field), 2);
    pulse(1, 0); pulse(1, 0);
    idle(3);
    chk("wrap_load_hour", cap_h, 10);
    chk("wrap_load_min", cap_m, 0);
    chk("wrap_load_sec", cap_s, 30);
    $display("wrap: loaded %0d:%0d:%0d", cap_h, cap_m, cap_s);

    // Mode and inc together: mode wins.
    set_cur(5, 6, 7);
    pulse(1, 0);
    pulse(1, 1);
    chk("both_field", int'(bus.set_field), 2);
    pulse(1, 0); pulse(1, 0);
    idle(3);
    chk("both_load_hour", cap_h, 5);
    chk("both_load_min", cap_m, 6);
    chk("both_load_sec", cap_s, 7);
    $display("both: loaded %0d:%0d:%0d", cap_h, cap_m, cap_s);

    // Timeout abort with blinking.
    loads_before = n_load;
    @(negedge clk); #1 blink_chg = 0;
    pulse(1, 0);
    idle(70);
    chk("timeout_blink_changes", blink_chg, 4);
    chk("timeout_no_load", n_load, loads_before);
    chk("timeout_run", int'(bus.run), 1);
    chk("timeout_field", int'(bus.set_field), 0);
    $display("timeout: blink changes %0d", blink_chg);

    // Randomized traffic against the model.
    for (int n = 0; n < 700; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 7) == 0)
        set_cur(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      drive(r < 8, (r < 2) || (r >= 8 && r < 22));
    end
    idle(80);
    $display("random: %0d loads so far", n_load);

    // Asynchronous reset in the middle of SET_SEC.
    set_cur(1, 2, 3);
    pulse(1, 0); pulse(1, 0); pulse(1, 0);
    chk("rst_pre_field", int'(bus.set_field), 3);
    loads_before = n_load;
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_run", int'(bus.run), 1);
    chk("rst_ms_tick", int'(bus.ms_tick), 0);
    chk("rst_load_en", int'(bus.load_en), 0);
    chk("rst_load_hour", int'(bus.load_hour), 0);
    chk("rst_load_min", int'(bus.load_min), 0);
    chk("rst_load_sec", int'(bus.load_sec), 0);
    chk("rst_field", int'(bus.set_field), 0);
    chk("rst_blink", int'(bus.blink), 0);
    repeat (3) @(negedge clk);
    chk("rst_no_load", n_load, loads_before);
    #1 rst_n = 1'b1;
    first_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.ms_tick && first_k < 0) first_k = k;
    end
    chk("rst_first_tick", first_k + 1, DIV);
    $display("reset: first tick on edge %0d", first_k + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
